jtag_tap_param: RTL and testbench

- Parametrised IEEE 1149.1-style test access port. Next generation of the team's TAP, IR, decoder, bypass and boundary-chain assembly.
- Adds:
  - a full 16-state TAP FSM;
  - configurable IR width and opcodes;
  - a 32-bit IDCODE register;
  - a boundary register of configurable length with separate capture/shift/update stages;
  - a falling-edge TDO with output enable;
  - a handshake-free internal-scan hook.
- Sits between the chip's JTAG pins and the core; pin muxing stays outside this block.

---
 rtl/jtag_pkg.sv | 31 +++
 rtl/jtag_tap_fsm.sv | 59 +++++
 rtl/jtag_tap_param.sv | 152 +++++++++++++++
 tb/tb_jtag_tap_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the parametrised JTAG TAP: state encodings,
// the IR capture pattern and the default opcode assignments.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PAU_DR = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PAU_IR = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_e;

  localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;

  localparam int unsigned DEF_OP_EXTEST  = 0;
  localparam int unsigned DEF_OP_SAMPLE  = 1;
  localparam int unsigned DEF_OP_IDCODE  = 2;
  localparam int unsigned DEF_OP_INTSCAN = 3;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register, next-state decode and
// per-state strobes consumed by the IR and data registers.
import jtag_pkg::*;

module jtag_tap_fsm (
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       tlr_next_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = TLR;
    case (state_q)
      TLR:    state_d = tms_i ? TLR    : RTI;
      RTI:    state_d = tms_i ? SEL_DR : RTI;
      SEL_DR: state_d = tms_i ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms_i ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms_i ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms_i ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms_i ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms_i ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms_i ? SEL_DR : RTI;
      SEL_IR: state_d = tms_i ? TLR    : CAP_IR;
      CAP_IR: state_d = tms_i ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms_i ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms_i ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms_i ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms_i ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms_i ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TLR;
    else          state_q <= state_d;
  end

  // Strobes mark the state during which the next rising TCK acts.
  assign state_o      = state_q;
  assign tlr_next_o   = (state_d == TLR);
  assign capture_dr_o = (state_q == CAP_DR);
  assign shift_dr_o   = (state_q == SH_DR);
  assign update_dr_o  = (state_q == UPD_DR);
  assign capture_ir_o = (state_q == CAP_IR);
  assign shift_ir_o   = (state_q == SH_IR);
  assign update_ir_o  = (state_q == UPD_IR);

endmodule

// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP: IR, IDCODE, bypass, boundary register with update
// stage, internal-scan hook and falling-edge TDO with output enable.
import jtag_pkg::*;

module jtag_tap_param #(
  parameter int unsigned IR_WIDTH   = 4,
  parameter int unsigned BSR_LEN    = 75,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001,
  parameter int unsigned OP_EXTEST  = DEF_OP_EXTEST,
  parameter int unsigned OP_SAMPLE  = DEF_OP_SAMPLE,
  parameter int unsigned OP_IDCODE  = DEF_OP_IDCODE,
  parameter int unsigned OP_INTSCAN = DEF_OP_INTSCAN
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                tdo_en,
  input  logic [BSR_LEN-1:0]  bsr_capture_in,
  output logic [BSR_LEN-1:0]  bsr_update_out,
  output logic                bs_mode,
  output logic                int_scan_en,
  output logic                int_scan_si,
  input  logic                int_scan_so,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_value
);

  localparam logic [IR_WIDTH-1:0] OPC_EXTEST  = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] OPC_SAMPLE  = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] OPC_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] OPC_INTSCAN = IR_WIDTH'(OP_INTSCAN);
  localparam logic [IR_WIDTH-1:0] IR_CAP      = IR_WIDTH'(IR_CAPTURE_PAT);

  tap_state_e state;
  logic tlr_next, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;

  jtag_tap_fsm u_fsm (
    .tck_i        (TCK),
    .trst_ni      (TRST),
    .tms_i        (TMS),
    .state_o      (state),
    .tlr_next_o   (tlr_next),
    .capture_dr_o (cap_dr),
    .shift_dr_o   (sh_dr),
    .update_dr_o  (upd_dr),
    .capture_ir_o (cap_ir),
    .shift_ir_o   (sh_ir),
    .update_ir_o  (upd_ir)
  );

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d, ir_q, ir_d;
  logic [BSR_LEN-1:0]  bsr_sr_q, bsr_sr_d, bsr_upd_q, bsr_upd_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic                byp_q, byp_d;
  logic                tdo_q, tdo_en_q;
  logic                sel_bsr, sel_id, sel_int, sel_byp, dr_so;

  // Any opcode not listed falls through to the 1-bit bypass path.
  assign sel_bsr = (ir_q == OPC_EXTEST) || (ir_q == OPC_SAMPLE);
  assign sel_id  = !sel_bsr && (ir_q == OPC_IDCODE);
  assign sel_int = !sel_bsr && !sel_id && (ir_q == OPC_INTSCAN);
  assign sel_byp = !(sel_bsr || sel_id || sel_int);

  assign dr_so = sel_bsr ? bsr_sr_q[0] :
                 sel_id  ? id_sr_q[0]  :
                 sel_int ? int_scan_so : byp_q;

  always_comb begin
    ir_sr_d   = ir_sr_q;
    ir_d      = ir_q;
    bsr_sr_d  = bsr_sr_q;
    bsr_upd_d = bsr_upd_q;
    id_sr_d   = id_sr_q;
    byp_d     = byp_q;

    if (cap_ir) begin
      ir_sr_d = IR_CAP;
    end else if (sh_ir) begin
      ir_sr_d = ir_sr_q >> 1;
      ir_sr_d[IR_WIDTH-1] = TDI;
    end

    if (tlr_next)    ir_d = OPC_IDCODE;
    else if (upd_ir) ir_d = ir_sr_q;

    if (cap_dr) begin
      if (sel_bsr) bsr_sr_d = bsr_capture_in;
      if (sel_id)  id_sr_d  = IDCODE_VAL;
      if (sel_byp) byp_d    = 1'b0;
    end else if (sh_dr) begin
      if (sel_bsr) begin
        bsr_sr_d = bsr_sr_q >> 1;
        bsr_sr_d[BSR_LEN-1] = TDI;
      end
      if (sel_id) begin
        id_sr_d = id_sr_q >> 1;
        id_sr_d[31] = TDI;
      end
      if (sel_byp) byp_d = TDI;
    end

    if (tlr_next)                bsr_upd_d = '0;
    else if (upd_dr && sel_bsr)  bsr_upd_d = bsr_sr_q;
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr_q   <= IR_CAP;
      ir_q      <= OPC_IDCODE;
      bsr_sr_q  <= '0;
      bsr_upd_q <= '0;
      id_sr_q   <= '0;
      byp_q     <= 1'b0;
    end else begin
      ir_sr_q   <= ir_sr_d;
      ir_q      <= ir_d;
      bsr_sr_q  <= bsr_sr_d;
      bsr_upd_q <= bsr_upd_d;
      id_sr_q   <= id_sr_d;
      byp_q     <= byp_d;
    end
  end

  // Falling-edge launch gives the board half a TCK of hold margin on TDO.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else if (sh_ir) begin
      tdo_q    <= ir_sr_q[0];
      tdo_en_q <= 1'b1;
    end else if (sh_dr) begin
      tdo_q    <= dr_so;
      tdo_en_q <= 1'b1;
    end else begin
      tdo_en_q <= 1'b0;
      if (state == TLR) tdo_q <= 1'b0;
    end
  end

  assign TDO            = tdo_q;
  assign tdo_en         = tdo_en_q;
  assign bsr_update_out = bsr_upd_q;
  assign bs_mode        = (ir_q == OPC_EXTEST);
  assign int_scan_en    = sel_int && sh_dr;
  assign int_scan_si    = TDI;
  assign tap_state      = state;
  assign ir_value       = ir_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: a default-length instance plus a
// BSR_LEN=1 instance driven from the same TAP pins.
module tb_jtag_tap_param;

  localparam int unsigned IR_W = 4;
  localparam int unsigned BSR  = 75;
  localparam logic [31:0] IDV  = 32'h1234_5679;

  logic             TCK = 1'b0;
  logic             TRST = 1'b0;
  logic             TMS = 1'b1;
  logic             TDI = 1'b0;
  logic [BSR-1:0]   bsr_capture_in = '0;
  logic             int_scan_so = 1'b0;
  logic             TDO, tdo_en, bs_mode, int_scan_en, int_scan_si;
  logic [BSR-1:0]   bsr_update_out;
  logic [3:0]       tap_state;
  logic [IR_W-1:0]  ir_value;

  logic [0:0]       cap1 = 1'b0;
  logic             TDO1, tdo_en1, bs_mode1, int_scan_en1, int_scan_si1;
  logic [0:0]       bsr_update_out1;
  logic [3:0]       tap_state1;
  logic [IR_W-1:0]  ir_value1;

  int checks = 0;
  int errors = 0;

  jtag_tap_param #(.IR_WIDTH(IR_W), .BSR_LEN(BSR), .IDCODE_VAL(IDV)) u_dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
    .bsr_capture_in(bsr_capture_in), .bsr_update_out(bsr_update_out),
    .bs_mode(bs_mode), .int_scan_en(int_scan_en), .int_scan_si(int_scan_si),
    .int_scan_so(int_scan_so), .tap_state(tap_state), .ir_value(ir_value)
  );

  jtag_tap_param #(.IR_WIDTH(IR_W), .BSR_LEN(1), .IDCODE_VAL(IDV)) u_dut1 (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO1), .tdo_en(tdo_en1),
    .bsr_capture_in(cap1), .bsr_update_out(bsr_update_out1),
    .bs_mode(bs_mode1), .int_scan_en(int_scan_en1), .int_scan_si(int_scan_si1),
    .int_scan_so(int_scan_so), .tap_state(tap_state1), .ir_value(ir_value1)
  );

  // Clock and watchdog
  always #10 TCK = ~TCK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change just after the falling edge, outputs are
  // sampled 1 ns after the following falling edge.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic goto_shdr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic exit_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic shift_bits(input int n, input logic [127:0] din,
                            output logic [127:0] dout, output logic [127:0] dout1,
                            output logic en_all);
    dout = '0;
    dout1 = '0;
    en_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      dout[i]  = TDO;
      dout1[i] = TDO1;
      en_all   = en_all & tdo_en;
      step(i == n - 1, din[i]);
    end
  endtask

  task automatic load_ir(input logic [IR_W-1:0] op, output logic [127:0] cap_out);
    logic [127:0] d1;
    logic         en;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(IR_W, {124'd0, op}, cap_out, d1, en);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Tests
  task automatic test_reset();
    TRST = 1'b0;
    TMS  = 1'b1;
    repeat (2) @(negedge TCK);
    #1;
    checks++; if (tap_state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", tap_state); end
    checks++; if (ir_value !== 4'd2) begin errors++; $display("FAIL reset_ir got %h exp 2", ir_value); end
    checks++; if (bsr_update_out !== '0) begin errors++; $display("FAIL reset_bsr_upd got %h exp 0", bsr_update_out); end
    checks++; if (bs_mode !== 1'b0) begin errors++; $display("FAIL reset_bs_mode got %b exp 0", bs_mode); end
    checks++; if (TDO !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b/%b exp 0/0", TDO, tdo_en); end
    checks++; if (int_scan_en !== 1'b0) begin errors++; $display("FAIL reset_int_scan_en got %b exp 0", int_scan_en); end
    TRST = 1'b1;
    @(negedge TCK);
    #1;
  endtask

  task automatic test_idcode();
    logic [127:0] d, d1;
    logic         en;
    step(1'b0, 1'b0);
    checks++; if (tdo_en !== 1'b0) begin errors++; $display("FAIL idle_tdo_en got %b exp 0", tdo_en); end
    goto_shdr();
    shift_bits(32, '0, d, d1, en);
    checks++; if (d[31:0] !== IDV) begin errors++; $display("FAIL idcode got %h exp %h", d[31:0], IDV); end
    checks++; if (en !== 1'b1) begin errors++; $display("FAIL idcode_tdo_en got %b exp 1", en); end
    checks++; if (tdo_en !== 1'b0) begin errors++; $display("FAIL exit1_tdo_en got %b exp 0", tdo_en); end
    exit_dr();
  endtask

  task automatic test_ir_bypass();
    logic [127:0] cap, d, d1;
    logic         en;
    load_ir(4'hF, cap);
    checks++; if (cap[3:0] !== 4'b0001) begin errors++; $display("FAIL ir_capture got %b exp 0001", cap[3:0]); end
    checks++; if (ir_value !== 4'hF) begin errors++; $display("FAIL ir_bypass got %h exp f", ir_value); end
    goto_shdr();
    shift_bits(5, 128'b01101, d, d1, en);
    checks++; if (d[4:0] !== 5'b11010) begin errors++; $display("FAIL bypass_stream got %b exp 11010", d[4:0]); end
    exit_dr();
    checks++; if (tap_state !== 4'd1) begin errors++; $display("FAIL bypass_rti got %0d exp 1", tap_state); end
    load_ir(4'h7, cap);
    goto_shdr();
    shift_bits(2, 128'b11, d, d1, en);
    checks++; if (d[1:0] !== 2'b10) begin errors++; $display("FAIL unknown_op_bypass got %b exp 10", d[1:0]); end
    exit_dr();
  endtask

  task automatic test_tlr_recovery();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++; if (tap_state !== 4'd11) begin errors++; $display("FAIL shir_state got %0d exp 11", tap_state); end
    repeat (5) step(1'b1, 1'b1);
    checks++; if (tap_state !== 4'd0) begin errors++; $display("FAIL tlr_recover_state got %0d exp 0", tap_state); end
    checks++; if (ir_value !== 4'd2) begin errors++; $display("FAIL tlr_recover_ir got %h exp 2", ir_value); end
    step(1'b0, 1'b0);
  endtask

  task automatic test_sample();
    logic [127:0] cap, d, d1, exp_d;
    logic         en;
    for (int i = 0; i < BSR; i++) bsr_capture_in[i] = i[0];
    cap1 = 1'b0;
    exp_d = '0;
    exp_d[BSR-1:0] = bsr_capture_in;
    load_ir(4'd1, cap);
    goto_shdr();
    shift_bits(BSR, '1, d, d1, en);
    checks++; if (d !== exp_d) begin errors++; $display("FAIL sample_stream got %h exp %h", d, exp_d); end
    checks++; if (d1[BSR-1:0] !== {{(BSR-1){1'b1}}, 1'b0}) begin errors++; $display("FAIL sample_len1_stream got %h", d1[BSR-1:0]); end
    exit_dr();
    checks++; if (bsr_update_out !== '1) begin errors++; $display("FAIL preload_update got %h exp all ones", bsr_update_out); end
    checks++; if (bsr_update_out1 !== 1'b1) begin errors++; $display("FAIL preload_len1_update got %b exp 1", bsr_update_out1); end
    checks++; if (bs_mode !== 1'b0) begin errors++; $display("FAIL sample_bs_mode got %b exp 0", bs_mode); end
  endtask

  task automatic test_extest_pause();
    logic [127:0] cap, da, db, d1, got, exp_d;
    logic [BSR-1:0] tdi_pat;
    logic         en;
    tdi_pat = {11'h5A3, 64'hDEAD_BEEF_0123_4567};
    for (int i = 0; i < BSR; i++) bsr_capture_in[i] = (i % 3 == 0);
    exp_d = '0;
    exp_d[BSR-1:0] = bsr_capture_in;
    load_ir(4'd0, cap);
    checks++; if (bs_mode !== 1'b1) begin errors++; $display("FAIL extest_bs_mode got %b exp 1", bs_mode); end
    goto_shdr();
    shift_bits(10, {53'd0, tdi_pat}, da, d1, en);
    repeat (3) step(1'b0, 1'b0);
    checks++; if (tap_state !== 4'd6) begin errors++; $display("FAIL pause_state got %0d exp 6", tap_state); end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(BSR - 10, {53'd0, tdi_pat} >> 10, db, d1, en);
    got = (da & 128'h3FF) | (db << 10);
    checks++; if (got !== exp_d) begin errors++; $display("FAIL pause_stream got %h exp %h", got, exp_d); end
    exit_dr();
    checks++; if (bsr_update_out !== tdi_pat) begin errors++; $display("FAIL extest_update got %h exp %h", bsr_update_out, tdi_pat); end
    checks++; if (bsr_update_out1 !== tdi_pat[BSR-1]) begin errors++; $display("FAIL extest_len1_update got %b exp %b", bsr_update_out1, tdi_pat[BSR-1]); end
  endtask

  task automatic test_intscan_trst();
    logic [127:0] cap;
    load_ir(4'd3, cap);
    checks++; if (int_scan_en !== 1'b0 || bs_mode !== 1'b0) begin errors++; $display("FAIL intscan_idle got en %b bs %b exp 0 0", int_scan_en, bs_mode); end
    int_scan_so = 1'b1;
    goto_shdr();
    checks++; if (int_scan_en !== 1'b1) begin errors++; $display("FAIL intscan_en got %b exp 1", int_scan_en); end
    checks++; if (TDO !== 1'b1 || tdo_en !== 1'b1) begin errors++; $display("FAIL intscan_tdo got %b/%b exp 1/1", TDO, tdo_en); end
    TDI = 1'b1;
    #1;
    checks++; if (int_scan_si !== 1'b1) begin errors++; $display("FAIL intscan_si got %b exp 1", int_scan_si); end
    int_scan_so = 1'b0;
    step(1'b0, 1'b1);
    checks++; if (TDO !== 1'b0) begin errors++; $display("FAIL intscan_so0 got %b exp 0", TDO); end
    #4;
    TRST = 1'b0;
    #1;
    checks++; if (tap_state !== 4'd0 || ir_value !== 4'd2) begin errors++; $display("FAIL trst_state got %0d/%h exp 0/2", tap_state, ir_value); end
    checks++; if (TDO !== 1'b0 || tdo_en !== 1'b0 || int_scan_en !== 1'b0) begin errors++; $display("FAIL trst_outputs got %b%b%b exp 000", TDO, tdo_en, int_scan_en); end
    checks++; if (bsr_update_out !== '0 || bsr_update_out1 !== 1'b0) begin errors++; $display("FAIL trst_update got %h exp 0", bsr_update_out); end
    TMS = 1'b1;
    #2;
    TRST = 1'b1;
    @(negedge TCK);
    #1;
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_bypass();
    test_tlr_recovery();
    test_sample();
    test_extest_pause();
    test_intscan_trst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
